// File: rtl/shunt_pkg.sv
// Shared constants and types for the shunt put/get link receive side.
package shunt_pkg;

    localparam int unsigned M     = 9;
    localparam int unsigned NCH   = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 2;

    typedef logic [M-1:0]  joined_t;
    typedef logic [CW-1:0] chan_t;

    typedef enum logic {
        RX_IDLE,
        RX_WAIT
    } rx_state_t;

endpackage

// File: rtl/shunt_rx_fifo.sv
// Per-channel synchronous FIFO holding joined vectors; head is visible while non-empty.
module shunt_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] head_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt == (AW+1)'(DEPTH));
    assign empty_o = (cnt == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/shunt_rx_chan_ctrl.sv
// Shunt link receiver: demuxes tagged vectors into per-channel FIFOs and serves sample requests,
// freezing a channel's design clock while its vector is outstanding. Option: SHUNT_RX_BYPASS_EN.
module shunt_rx_chan_ctrl
    import shunt_pkg::*;
#(
    parameter int unsigned NUM_CH = NCH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lnk_valid_i,
    output logic                  lnk_ready_o,
    input  logic [CW-1:0]         lnk_chan_i,
    input  logic [M-1:0]          lnk_data_i,
    input  logic [NUM_CH-1:0]     req_i,
    output logic [NUM_CH-1:0]     freeze_clk_o,
    output logic [NUM_CH*M-1:0]   data_o,
    output logic [NUM_CH-1:0]     upd_o,
    output logic [NUM_CH-1:0]     ovr_err_o,
    output logic                  tag_err_o
);

    localparam int unsigned NTAG = 32'(1) << CW;

    logic [NTAG-1:0]            tag_ok;
    logic [NTAG-1:0]            full_ext;
    logic [NUM_CH-1:0]          full;
    logic [NUM_CH-1:0]          empty;
    logic [NUM_CH-1:0]          lnk_hit;
    logic [NUM_CH-1:0]          push;
    logic [NUM_CH-1:0]          pop;
    logic [NUM_CH-1:0]          byp;
    logic [NUM_CH-1:0]          ovr_set;
    joined_t [NUM_CH-1:0]       head;
    joined_t [NUM_CH-1:0]       data_q;
    logic [NUM_CH-1:0]          upd_q;
    logic [NUM_CH-1:0]          ovr_q;
    logic                       tag_q;
    logic                       xfer;
    rx_state_t                  state_q [NUM_CH];
    rx_state_t                  state_d [NUM_CH];

    // Tags with no channel behind them read as never-full so they drain and get flagged.
    assign full_ext    = NTAG'(full);
    assign lnk_ready_o = ~rst_i & ~full_ext[lnk_chan_i];
    assign xfer        = lnk_valid_i & lnk_ready_o;

    for (genvar t = 0; t < NTAG; t++) begin : g_tag
        if (t < NUM_CH) begin : g_ok
            assign tag_ok[t] = 1'b1;
        end else begin : g_bad
            assign tag_ok[t] = 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign lnk_hit[g] = xfer & (lnk_chan_i == chan_t'(g));
        assign push[g]    = lnk_hit[g] & ~byp[g];

        shunt_rx_fifo #(
            .DEPTH (DEPTH),
            .W     (M)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[g]),
            .pop_i   (pop[g]),
            .din_i   (lnk_data_i),
            .head_o  (head[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );

        // Freeze goes up in the request cycle itself so the design clock never sees a stale sample.
        assign freeze_clk_o[g] = ~rst_i & ((state_q[g] == RX_WAIT) |
                                           ((state_q[g] == RX_IDLE) & req_i[g] & empty[g]));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= RX_IDLE;
        end else begin
            for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
        end
    end

    // Per-channel next state, pop and bypass decisions.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) state_d[c] = state_q[c];
        pop     = '0;
        byp     = '0;
        ovr_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            case (state_q[c])
                RX_IDLE: begin
                    if (req_i[c]) begin
                        if (!empty[c]) pop[c] = 1'b1;
                        else           state_d[c] = RX_WAIT;
                    end
                end
                RX_WAIT: begin
                    ovr_set[c] = req_i[c];
                    if (!empty[c]) begin
                        pop[c]     = 1'b1;
                        state_d[c] = RX_IDLE;
                    end
`ifdef SHUNT_RX_BYPASS_EN
                    else if (lnk_hit[c]) begin
                        byp[c]     = 1'b1;
                        state_d[c] = RX_IDLE;
                    end
`endif
                end
                default: state_d[c] = RX_IDLE;
            endcase
        end
    end

    // Held vectors, update strobes and sticky error flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= '0;
            upd_q  <= '0;
            ovr_q  <= '0;
            tag_q  <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                upd_q[c] <= pop[c] | byp[c];
                if (pop[c])      data_q[c] <= head[c];
                else if (byp[c]) data_q[c] <= lnk_data_i;
                ovr_q[c] <= ovr_q[c] | ovr_set[c];
            end
            tag_q <= tag_q | (xfer & ~tag_ok[lnk_chan_i]);
        end
    end

    assign data_o    = data_q;
    assign upd_o     = upd_q;
    assign ovr_err_o = ovr_q;
    assign tag_err_o = tag_q;

endmodule
